icache_param: RTL
=================

// Module: icache_param
// PURPOSE
//  Parametrised blocking instruction cache between the IF stage and the AXI read bridge.
//  Configurable ways, sets, line size and fetch width. Adds three things to the fixed 4-way/64B cache:
//   uncached fetch, CACOP invalidation (by index, by hit, or all) and round-robin replacement per set.
//  Hit pipeline: request stage -> lookup stage. Hits complete back-to-back; a miss stalls in the FSM.
// PARAMETERS
//  WAYS         2   associativity; power of 2, 1..8
//  SETS         64  sets per way; power of 2, >=2
//  LINE_WORDS   16  32-bit words per line; power of 2, >=FETCH_WORDS
//  FETCH_WORDS  2   words returned per fetch; power of 2, 1..4
//  COOKIE_WIDTH 32  opaque sideband carried with each request
//  Derived: OFF=log2(LINE_WORDS*4), IDX=log2(SETS), TAG=32-OFF-IDX
// PORTS
//  clk          in   1            clock
//  rst          in   1            async reset, active-high
//  valid        in   1            fetch request; accepted when valid&cache_ready
//  pc_in        in   32           virtual fetch address (index source)
//  p_addr       in   32           physical address for the same request (tag source)
//  uncached     in   1            fetch bypasses the arrays
//  cookie_in    in   COOKIE_WIDTH sideband, returned unchanged
//  cacop_valid  in   1            maintenance request; wins over valid in the same cycle
//  cacop_op     in   2            0 index-inv (way=addr[OFF+IDX+:log2 WAYS]), 1 hit-inv, 2 inv-all, 3 nop
//  cacop_addr   in   32           cacop address
//  cacop_done   out  1            1-cycle pulse when the cacop completes
//  cache_ready  out  1            can accept a fetch or cacop this cycle
//  data_valid   out  1            1-cycle pulse; r_data_CPU/pc_out/cookie_out/exception valid
//  r_data_CPU   out  32*FETCH_WORDS  fetch block; lowest address in [31:0]
//  pc_out       out  32           pc of the completing request
//  cookie_out   out  COOKIE_WIDTH cookie of the completing request
//  exception    out  7            bit0 = ADEF (pc[1:0]!=0); bits 6:1 = 0
//  r_req        out  1            AXI read request; held until r_rdy
//  r_addr       out  32           line-aligned (cached) or fetch-block-aligned (uncached) address
//  r_len        out  8            beats-1: LINE_WORDS-1 or FETCH_WORDS-1
//  r_rdy        in   1            request handshake
//  ret_valid    in   1            return beat valid
//  ret_last     in   1            final beat
//  r_data_AXI   in   32           return data
//  r_data_ready out  1            high in REFILL/UNC_WAIT; beats are consumed only then
// BEHAVIOUR
//  Reset: state=IDLE; all valid bits=0; round-robin pointers=0; every output 0 except cache_ready=1.
//  Arrays are flop-based. Tag/data are unknown after reset; valid bits gate every hit.
//  Fetch block = words at pc[OFF-1:2] rounded down to a FETCH_WORDS boundary.
//  States: IDLE, LOOKUP, MISS, REFILL, UNC_WAIT, RESP, CACOP_ALL.
//  IDLE/LOOKUP accept: latch pc/p_addr/cookie/uncached; read set pc_in[OFF+:IDX]; next state LOOKUP.
//  LOOKUP, ADEF: data_valid=1, data=0, no AXI access.
//  LOOKUP, hit (valid & tag==p_addr[31:32-TAG]): data_valid the same cycle, so latency is 1 cycle after accept.
//   cache_ready=1 in LOOKUP-hit, so a new request may be accepted (1 fetch/cycle).
//  LOOKUP, miss: cache_ready=0 and no data_valid; go to MISS.
//   The victim is the first invalid way, else rr[set]; it is captured now.
//  LOOKUP, uncached: same path as a miss, with r_len=FETCH_WORDS-1. No array read result is used.
//  MISS: r_req=1 with r_addr/r_len stable until r_rdy. Then REFILL (cached) or UNC_WAIT (uncached).
//  REFILL: beat k is written to fill buffer word k.
//   On ret_last: write the line, tag and valid into the victim way, and set rr[set]=victim+1 mod WAYS.
//   Then go to RESP.
//  UNC_WAIT: collect FETCH_WORDS beats; no array or rr update; on ret_last go to RESP.
//  RESP: data_valid=1 with data from the fill buffer, then IDLE. Back-to-back acceptance starts in IDLE.
//  A beat count mismatch with ret_last is not checked. ret_valid outside REFILL/UNC_WAIT is ignored.
//  CACOP is accepted only in IDLE (cache_ready=1, no fetch in flight).
//   op0/op1: one cycle of lookup, clear the selected valid bit (op1 clears only on a hit), then cacop_done.
//   op3: cacop_done next cycle.
//   op2: CACOP_ALL walks the sets 0..SETS-1, one set per cycle, clearing all ways.
//    cacop_done follows SETS cycles after acceptance.
//  A fill write and a cacop never coincide, because a cacop is IDLE-only.
//  Async reset mid-refill: return to IDLE immediately with everything invalid.
//   The bridge must also be reset; stale beats are ignored in IDLE.
// TESTING
//  1 Cold miss, pc=p_addr=0x1C000040, WAYS=2. Expect:
//    r_req with r_addr=0x1C000040, r_len=15; 16 beats of 0xA0+k.
//    data_valid in RESP with r_data_CPU={0xA1,0xA0}; way0 filled.
//  2 Refetch 0x1C000048 then 0x1C000050 on consecutive cycles.
//    -> two hits, data_valid on consecutive cycles, data {0xA3,0xA2} then {0xA5,0xA4}, no r_req.
//  3 Three lines mapping to set 1 (tags 1,2,3).
//    -> fills go to way0, way1, then way0 (rr). The refetch of tag1 misses.
//  4 uncached fetch at 0x1FE00008 -> r_len=1, r_addr=0x1FE00008, 2 beats returned;
//    the same address later still misses (no allocation).
//  5 cacop op1 on a cached line -> cacop_done 2 cycles after accept; the next fetch there misses.
//    op2 -> cacop_done SETS cycles after accept; all lines miss.
//  6 pc=0x1C000042 -> exception[0]=1, data 0, no r_req.
//    Separately, assert rst during REFILL beat 5 -> outputs as reset, and the line is not valid afterwards.

Source files
------------

// File: rtl/icache_param.sv
// Parametrised blocking instruction cache: flop-based tag/data arrays, round-robin
// replacement per set, uncached fetch and CACOP maintenance (index, hit, all).
module icache_param #(
    parameter int WAYS         = 2,
    parameter int SETS         = 64,
    parameter int LINE_WORDS   = 16,
    parameter int FETCH_WORDS  = 2,
    parameter int COOKIE_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               p_addr,
    input  logic                      uncached,
    input  logic [COOKIE_WIDTH-1:0]   cookie_in,
    input  logic                      cacop_valid,
    input  logic [1:0]                cacop_op,
    input  logic [31:0]               cacop_addr,
    output logic                      cacop_done,
    output logic                      cache_ready,
    output logic                      data_valid,
    output logic [32*FETCH_WORDS-1:0] r_data_CPU,
    output logic [31:0]               pc_out,
    output logic [COOKIE_WIDTH-1:0]   cookie_out,
    output logic [6:0]                exception,
    output logic                      r_req,
    output logic [31:0]               r_addr,
    output logic [7:0]                r_len,
    input  logic                      r_rdy,
    input  logic                      ret_valid,
    input  logic                      ret_last,
    input  logic [31:0]               r_data_AXI,
    output logic                      r_data_ready
);

    localparam int OFF = $clog2(LINE_WORDS * 4);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - OFF - IDX;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LWW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_UNC_WAIT, S_RESP, S_CACOP_ALL, S_CACOP_LK
    } state_t;

    state_t                  state_q;
    logic [31:0]             pc_q;
    logic [31:0]             pa_q;
    logic [COOKIE_WIDTH-1:0] cookie_q;
    logic                    unc_q;
    logic [IDX-1:0]          idx_q;
    logic [WW-1:0]           victim_q;
    logic                    r_req_q;
    logic [31:0]             r_addr_q;
    logic [7:0]              r_len_q;
    logic [LWW-1:0]          cnt_q;
    logic [31:0]             fill_q [LINE_WORDS];
    logic                    cacop_done_q;
    logic [1:0]              cop_op_q;
    logic [IDX-1:0]          cop_idx_q;
    logic [TAG-1:0]          cop_tag_q;
    logic [WW-1:0]           cop_way_q;
    logic [IDX-1:0]          walk_q;

    logic [SETS-1:0]         valid_q [WAYS];
    logic [WW-1:0]           rr_q    [SETS];
    logic [TAG-1:0]          tag_q   [WAYS][SETS];
    logic [31:0]             data_q  [WAYS][SETS][LINE_WORDS];

    logic [WAYS-1:0]          hit_vec_s;
    logic                     hit_s;
    logic [WW-1:0]            hit_way_s;
    logic                     adef_s;
    logic                     lk_done_s;
    logic                     accept_fetch_s;
    logic                     accept_cop_s;
    logic [WW-1:0]            vic_s;
    logic [WW-1:0]            rr_next_s;
    logic [LWW-1:0]           word_base_s;
    logic [32*FETCH_WORDS-1:0] rdata_s;
    logic [31:0]              line_s [LINE_WORDS];
    logic                     fill_we_s;
    logic [WAYS-1:0]          cop_hit_vec_s;
    logic                     cop_clr_s;
    logic [WW-1:0]            cop_way_s;
    logic                     unused_s;

    assign unused_s = ^{cacop_addr[OFF-1:0]};

    // Tag compare of the latched set against the physical tag
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_q[w][idx_q] && (tag_q[w][idx_q] == pa_q[31:32-TAG]);
            hit_way_s    = hit_vec_s[w] ? WW'(w) : hit_way_s;
        end
    end

    assign hit_s          = |hit_vec_s;
    assign adef_s         = (pc_q[1:0] != 2'b00);
    assign lk_done_s      = (state_q == S_LOOKUP) && (adef_s || (!unc_q && hit_s));
    assign cache_ready    = (state_q == S_IDLE) || lk_done_s;
    assign accept_cop_s   = (state_q == S_IDLE) && cacop_valid;
    assign accept_fetch_s = cache_ready && valid && !cacop_valid;
    assign word_base_s    = LWW'(pc_q >> 2) & ~LWW'(FETCH_WORDS - 1);
    assign rr_next_s      = (victim_q == WW'(WAYS - 1)) ? WW'(0) : victim_q + WW'(1);
    assign fill_we_s      = (state_q == S_REFILL) && ret_valid && ret_last;

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        vic_s = rr_q[idx_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            vic_s = valid_q[w][idx_q] ? vic_s : WW'(w);
        end
    end

    // Fetch block mux: array on a lookup hit, fill buffer in RESP, zero otherwise
    always_comb begin
        rdata_s = '0;
        for (int f = 0; f < FETCH_WORDS; f++) begin
            if (lk_done_s && !adef_s) begin
                rdata_s[32*f +: 32] = data_q[hit_way_s][idx_q][word_base_s + LWW'(f)];
            end else if (state_q == S_RESP) begin
                rdata_s[32*f +: 32] = unc_q ? fill_q[LWW'(f)] : fill_q[word_base_s + LWW'(f)];
            end else begin
                rdata_s[32*f +: 32] = 32'd0;
            end
        end
    end

    // Line written on the final beat includes that beat, not yet in the fill buffer
    always_comb begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            line_s[k] = fill_q[k];
        end
        line_s[cnt_q] = r_data_AXI;
    end

    // CACOP index/hit lookup target
    always_comb begin
        cop_hit_vec_s = '0;
        cop_way_s     = cop_way_q;
        for (int w = 0; w < WAYS; w++) begin
            cop_hit_vec_s[w] = valid_q[w][cop_idx_q] && (tag_q[w][cop_idx_q] == cop_tag_q);
            cop_way_s = (cop_op_q == 2'd1 && cop_hit_vec_s[w]) ? WW'(w) : cop_way_s;
        end
        case (cop_op_q)
            2'd0:    cop_clr_s = 1'b1;
            2'd1:    cop_clr_s = |cop_hit_vec_s;
            default: cop_clr_s = 1'b0;
        endcase
    end

    // Main controller: request latching, miss handling, refill, valid bits and round-robin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 32'd0;
            pa_q         <= 32'd0;
            cookie_q     <= '0;
            unc_q        <= 1'b0;
            idx_q        <= '0;
            victim_q     <= '0;
            r_req_q      <= 1'b0;
            r_addr_q     <= 32'd0;
            r_len_q      <= 8'd0;
            cnt_q        <= '0;
            cacop_done_q <= 1'b0;
            cop_op_q     <= 2'd0;
            cop_idx_q    <= '0;
            cop_tag_q    <= '0;
            cop_way_q    <= '0;
            walk_q       <= '0;
            for (int k = 0; k < LINE_WORDS; k++) fill_q[k] <= 32'd0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            cacop_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOOKUP: begin
                    if (accept_cop_s) begin
                        cop_op_q  <= cacop_op;
                        cop_idx_q <= cacop_addr[OFF +: IDX];
                        cop_tag_q <= cacop_addr[31:32-TAG];
                        cop_way_q <= (WAYS == 1) ? WW'(0) : cacop_addr[OFF+IDX +: WW];
                        case (cacop_op)
                            2'd0, 2'd1: state_q <= S_CACOP_LK;
                            2'd2: begin
                                for (int w = 0; w < WAYS; w++) valid_q[w][0] <= 1'b0;
                                walk_q  <= IDX'(1);
                                state_q <= S_CACOP_ALL;
                            end
                            default: begin
                                cacop_done_q <= 1'b1;
                                state_q      <= S_IDLE;
                            end
                        endcase
                    end else if (accept_fetch_s) begin
                        pc_q     <= pc_in;
                        pa_q     <= p_addr;
                        cookie_q <= cookie_in;
                        unc_q    <= uncached;
                        idx_q    <= pc_in[OFF +: IDX];
                        state_q  <= S_LOOKUP;
                    end else if (state_q == S_LOOKUP && !lk_done_s) begin
                        victim_q <= vic_s;
                        r_req_q  <= 1'b1;
                        r_addr_q <= unc_q ? (pa_q & ~(32'(FETCH_WORDS * 4) - 32'd1))
                                          : (pa_q & ~(32'(LINE_WORDS * 4) - 32'd1));
                        r_len_q  <= unc_q ? 8'(FETCH_WORDS - 1) : 8'(LINE_WORDS - 1);
                        state_q  <= S_MISS;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MISS: begin
                    if (r_rdy) begin
                        r_req_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= unc_q ? S_UNC_WAIT : S_REFILL;
                    end else begin
                        state_q <= S_MISS;
                    end
                end
                S_REFILL, S_UNC_WAIT: begin
                    if (ret_valid) begin
                        fill_q[cnt_q] <= r_data_AXI;
                        cnt_q         <= cnt_q + LWW'(1);
                        if (ret_last) begin
                            state_q <= S_RESP;
                            if (state_q == S_REFILL) begin
                                valid_q[victim_q][idx_q] <= 1'b1;
                                rr_q[idx_q]              <= rr_next_s;
                            end
                        end
                    end
                end
                S_RESP: state_q <= S_IDLE;
                S_CACOP_LK: begin
                    if (cop_clr_s) begin
                        valid_q[cop_way_s][cop_idx_q] <= 1'b0;
                    end
                    cacop_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_CACOP_ALL: begin
                    for (int w = 0; w < WAYS; w++) valid_q[w][walk_q] <= 1'b0;
                    if (walk_q == IDX'(SETS - 1)) begin
                        cacop_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        walk_q <= walk_q + IDX'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate every hit
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            tag_q[victim_q][idx_q] <= pa_q[31:32-TAG];
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[victim_q][idx_q][k] <= line_s[k];
            end
        end
    end

    assign data_valid   = lk_done_s || (state_q == S_RESP);
    assign r_data_CPU   = rdata_s;
    assign pc_out       = pc_q;
    assign cookie_out   = cookie_q;
    assign exception    = {6'b000000, lk_done_s && adef_s};
    assign r_req        = r_req_q;
    assign r_addr       = r_addr_q;
    assign r_len        = r_len_q;
    assign cacop_done   = cacop_done_q;
    assign r_data_ready = (state_q == S_REFILL) || (state_q == S_UNC_WAIT);

endmodule
